alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Parametrised, registered successor to the combinational ALU, for the pipelined datapath.
//   - Accepts one operation per valid/ready handshake.
//   - Returns the result with a registered output handshake.
//   - Keeps an architectural NZCV flag register, updated on request.
//   - Sources carry-in from its own C flag.
//   - Optional multi-cycle iterative multiply.
// PARAMETERS
//   WIDTH      32  operand/result width (>=4)
//   FLAG_RST   0   reset value of NZCV register (4 bits, {N,Z,C,V})
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation presented
//   in_ready   out  1      unit can accept operation this cycle
//   op         in   4      opcode (table below)
//   set_flags  in   1      update NZCV from this op's result
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result/out_flags valid
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  registered result
//   out_flags  out  4      NZCV computed for this result (regardless of set_flags)
//   flags      out  4      current architectural NZCV register
// BEHAVIOUR
//   Reset: in_ready=1, out_valid=0, result=0, out_flags=0, flags=FLAG_RST, FSM=IDLE.
//   Opcodes
//     0000 AND   0001 EOR   0010 A-B   0011 B-A   0100 A+B   0101 A+B+C
//     0110 A-B-!C   0111 B-A-!C   1000 MUL   1100 ORR   1101 MOV B
//     1110 BIC (A&~B)   1111 MVN (~B)   others -> result 0, C=V=0
//   Flags
//     - N = result[WIDTH-1]; Z = (result==0).
//     - add: C = carry-out of WIDTH+1-bit sum.
//     - sub: C = NOT borrow, i.e. A>=B unsigned for A-B (includes !C term for carry forms).
//     - V = signed overflow for add/sub.
//     - Logic/move/MUL: C and V keep previous flags value.
//   Handshake
//     - in_ready = (state==IDLE) && (!out_valid || out_ready).
//     - Accept when in_valid && in_ready.
//     - Output holds stable while out_valid && !out_ready.
//   Latency
//     - Single-cycle ops: out_valid asserts the cycle after accept.
//       Back-to-back throughput is 1/cycle when out_ready=1.
//     - MUL: see CONFIGURATION.
//   FSM: IDLE -> (accept MUL) MUL_BUSY -> (count==WIDTH-1) IDLE with out_valid=1.
//     - Other ops stay in IDLE.
//   Carry source: carry ops use flags.C as of the accept cycle.
//     - A flag update from the immediately preceding accepted op is already visible (no hazard).
//   Flag update: if set_flags, flags <= out_flags in the same edge that loads result.
//   Simultaneous out_ready and new accept: old result retires, new one loads in the same edge.
//   Reset mid-MUL: aborts immediately, all state to reset values, no partial result emitted.
// CONFIGURATION
//   ALU_MUL_EN defined:
//     - op 1000 = unsigned shift-add multiply, low WIDTH bits of A*B.
//     - Takes exactly WIDTH cycles in MUL_BUSY; out_valid on cycle WIDTH+1 after accept.
//     - in_ready=0 throughout MUL_BUSY.
//   ALU_MUL_EN undefined:
//     - op 1000 treated as undefined: single-cycle, result 0, C=V=0.
//     - No MUL_BUSY state or multiplier registers synthesised.
// TESTING
//   1. Reset and flag update (WIDTH=32, FLAG_RST=0):
//      - Release reset, then send op=0100, a=FFFFFFFF, b=1, set_flags=1.
//      - Expect result=0, out_flags=0110 (Z,C) one cycle later.
//      - Expect flags=0110.
//   2. Carry chain:
//      - After test 1, send op=0101, a=1, b=1, set_flags=0.
//      - Expect result=3; flags stay 0110.
//   3. Subtract and BIC:
//      - op=0010, a=80000000, b=1, set_flags=1: expect result=7FFFFFFF, NZCV=0011.
//      - op=1110, a=FF, b=0F: expect result=F0.
//   4. Backpressure:
//      - Hold out_ready=0 with 2 ops offered back-to-back.
//      - Expect in_ready=0 after the first accept, and result stable.
//      - Raise out_ready: second op is accepted in the same cycle the first retires.
//   5. MUL (ALU_MUL_EN defined):
//      - a=12345, b=100: expect result=1234500 exactly 33 cycles after accept; in_ready low meanwhile.
//      - Without the macro: result=0 one cycle after accept.
//   6. Reset mid-MUL:
//      - Assert rst_n=0 at cycle 10 of MUL.
//      - Expect out_valid=0 and flags=FLAG_RST immediately.
//      - After release, the first op completes normally.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshakes, an architectural
// NZCV flag register and an optional iterative shift-add multiplier.
// Optional feature macro: ALU_MUL_EN (enables op 4'b1000 as a WIDTH-cycle multiply).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting ops; single-cycle results load on the accept edge
// MUL_BUSY | shift-add multiply in progress, input side stalled
module alu_seq_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic accept;
    logic load_alu;

    // ALU datapath signals; subtraction is done as x + ~y + cin so that the
    // adder carry-out is directly the NOT-borrow C flag.
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             is_arith;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

`ifdef ALU_MUL_EN
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_sum;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_sf;
    logic [3:0]       mul_flags;

    assign mul_sum   = mul_acc + (mul_b[0] ? mul_a : '0);
    assign mul_flags = {mul_sum[MSB], (mul_sum == '0), flags[1:0]};
`endif

    // Combinational ALU: operand selection for the shared adder, then result and C/V.
    always_comb begin
        add_x    = a;
        add_y    = b;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        alu_res  = '0;
        alu_c    = flags[1];
        alu_v    = flags[0];
        case (op)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a ^ b;
            4'b0010: begin add_y = ~b; add_cin = 1'b1; is_arith = 1'b1; end
            4'b0011: begin add_x = b; add_y = ~a; add_cin = 1'b1; is_arith = 1'b1; end
            4'b0100: is_arith = 1'b1;
            4'b0101: begin add_cin = flags[1]; is_arith = 1'b1; end
            4'b0110: begin add_y = ~b; add_cin = flags[1]; is_arith = 1'b1; end
            4'b0111: begin add_x = b; add_y = ~a; add_cin = flags[1]; is_arith = 1'b1; end
            4'b1100: alu_res = a | b;
            4'b1101: alu_res = b;
            4'b1110: alu_res = a & ~b;
            4'b1111: alu_res = ~b;
            default: begin
                // Undefined opcodes (and MUL when the multiplier is absent).
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        if (is_arith) begin
            alu_res = add_sum[MSB:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (add_x[MSB] == add_y[MSB]) && (add_sum[MSB] != add_x[MSB]);
        end
        alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end

    // Handshake decode and next-state logic.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
`ifdef ALU_MUL_EN
        is_mul   = (op == 4'b1000);
        load_alu = accept && !is_mul;
        mul_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mul_cnt == '0) begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        load_alu = accept;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ALU_MUL_EN
    // Iterative multiplier: one partial product per cycle, down-counter ends at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_cnt <= '0;
            mul_sf  <= 1'b0;
        end else if (accept && is_mul) begin
            mul_acc <= '0;
            mul_a   <= a;
            mul_b   <= b;
            mul_cnt <= CNT_W'(WIDTH - 1);
            mul_sf  <= set_flags;
        end else if (state_q == MUL_BUSY) begin
            mul_acc <= mul_sum;
            mul_a   <= {mul_a[MSB-1:0], 1'b0};
            mul_b   <= {1'b0, mul_b[MSB:1]};
            mul_cnt <= mul_cnt - 1'b1;
        end
    end
`endif

    // Output register and architectural flags; a retiring result and a new
    // load on the same edge simply overwrite, keeping out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_flags <= 4'b0000;
            flags     <= FLAG_RST;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            out_flags <= alu_flags;
            if (set_flags) begin
                flags <= alu_flags;
            end
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_sum;
            out_flags <= mul_flags;
            if (mul_sf) begin
                flags <= mul_flags;
            end
        end
`endif
        else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with a scoreboard of expected results.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq_unit;

    localparam int         W  = 32;
    localparam logic [3:0] FR = 4'b0000;
    localparam longint     SMAX = 64'sd2147483647;
    localparam longint     SMIN = -64'sd2147483648;
`ifdef ALU_MUL_EN
    localparam int         MUL_LAT = W + 1;
`else
    localparam int         MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         set_flags;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   out_flags;
    logic [3:0]   flags;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  of;
        logic [3:0]  fl;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] m_flags;
    int         checks = 0;
    int         errors = 0;
    int         n;
    int         lat;

    alu_seq_unit #(.WIDTH(W), .FLAG_RST(FR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .set_flags(set_flags), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_flags(out_flags), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model written from the opcode table using wide integer arithmetic.
    function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [3:0] f, output logic [31:0] r, output logic [3:0] nf);
        logic   c, v;
        longint ua, ub, sa, sb, full, sfull, k;
        c  = f[1];
        v  = f[0];
        r  = '0;
        ua = longint'({32'h0, ma});
        ub = longint'({32'h0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            4'd0:  r = ma & mb;
            4'd1:  r = ma ^ mb;
            4'd12: r = ma | mb;
            4'd13: r = mb;
            4'd14: r = ma & ~mb;
            4'd15: r = ~mb;
`ifdef ALU_MUL_EN
            4'd8:  r = ma * mb;
`endif
            4'd4, 4'd5: begin
                k     = (mop == 4'd5) ? longint'(f[1]) : 0;
                full  = ua + ub + k;
                r     = full[31:0];
                c     = full >= 64'sd4294967296;
                sfull = sa + sb + k;
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            4'd2, 4'd6: begin
                k     = (mop == 4'd6) ? longint'(!f[1]) : 0;
                full  = ua - ub - k;
                r     = full[31:0];
                c     = ua >= (ub + k);
                sfull = sa - sb - k;
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            4'd3, 4'd7: begin
                k     = (mop == 4'd7) ? longint'(!f[1]) : 0;
                full  = ub - ua - k;
                r     = full[31:0];
                c     = ub >= (ua + k);
                sfull = sb - sa - k;
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        nf = {r[31], (r == 32'h0), c, v};
    endfunction

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic sf);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        set_flags = sf;
    endtask

    // Waits for the presented op to be accepted; records the expectation on acceptance.
    task automatic wait_accept(output int cyc);
        logic [31:0] r;
        logic [3:0]  f;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!in_ready && cyc < 200);
        chk("accept", in_ready, 1);
        if (in_ready) begin
            model(op, a, b, m_flags, r, f);
            if (set_flags) m_flags = f;
            sb_q.push_back('{res: r, of: f, fl: m_flags});
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic sf);
        int c;
        drive(o, x, y, sf);
        wait_accept(c);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a result that will retire on the coming edge is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed result %0h, expected no output", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_result", result, mon_e.res);
                chk("sb_out_flags", out_flags, mon_e.of);
                chk("sb_flags", flags, mon_e.fl);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        set_flags = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        m_flags   = FR;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_flags", flags, FR);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Add with carry-out and zero result, flags written.
        send(4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b1);
        idle();
        @(negedge clk);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_result", result, 32'h0);
        chk("t1_out_flags", out_flags, 4'b0110);
        chk("t1_flags", flags, 4'b0110);

        // Carry chain uses the C flag set by the previous op.
        send(4'b0101, 32'h1, 32'h1, 1'b0);
        idle();
        @(negedge clk);
        chk("t2_result", result, 32'h3);
        chk("t2_flags", flags, 4'b0110);

        // Subtract with overflow, then BIC back-to-back.
        send(4'b0010, 32'h8000_0000, 32'h1, 1'b1);
        send(4'b1110, 32'hFF, 32'h0F, 1'b0);
        chk("t3_sub_result", result, 32'h7FFF_FFFF);
        chk("t3_sub_flags", out_flags, 4'b0011);
        idle();
        @(negedge clk);
        chk("t3_bic_result", result, 32'hF0);
        chk("t3_flags", flags, 4'b0011);

        // Backpressure: second op stalls until the first retires.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(4'b0001, 32'hF0F0, 32'hFF00, 1'b0);
        drive(4'b1100, 32'h1, 32'h2, 1'b0);
        @(negedge clk);
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_result", result, 32'h0FF0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_result", result, 32'h0FF0);
            chk("t4_hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept(n);
        chk("t4_same_cycle_accept", n, 1);
        idle();
        @(negedge clk);
        chk("t4_second_result", result, 32'h3);

        // Multiply latency and result.
        send(4'b1000, 32'd12345, 32'd100, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) chk("t5_busy_in_ready", in_ready, 0);
        end while (!out_valid && lat < 100);
        chk("t5_latency", lat, MUL_LAT);
`ifdef ALU_MUL_EN
        chk("t5_result", result, 32'd1234500);
`else
        chk("t5_result", result, 32'd0);
`endif

        // Reset in the middle of a multiply.
        send(4'b1000, 32'd7, 32'd9, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_flags", flags, FR);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_result", result, 0);
        sb_q.delete();
        m_flags = FR;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_partial", out_valid, 0);
        end
        send(4'b0100, 32'd5, 32'd6, 1'b1);
        idle();
        @(negedge clk);
        chk("t6_after_result", result, 32'd11);
        chk("t6_after_flags", flags, 4'b0000);

        // Every opcode with random operands, scoreboard-checked.
        repeat (2) begin
            for (int i = 0; i < 16; i++) begin
                send(4'(i), $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
        end
        send(4'b0010, 32'h5, 32'h5, 1'b1);
        send(4'b0110, 32'h5, 32'h5, 1'b1);
        send(4'b0111, 32'h0, 32'hFFFF_FFFF, 1'b1);
        idle();
        repeat (50) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
